// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg: shared constants, state encoding and round-robin search helper
package rr_arbiter4_pkg;
  localparam int NREQ = 4;
  localparam int IW = 2;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  // First set bit of r scanning upward from s, wrapping mod NREQ
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] s);
    rr_pick = s;
    for (int k = NREQ - 1; k >= 0; k--)
      if (r[s + IW'(k)]) rr_pick = s + IW'(k);
  endfunction
endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between requesters and the arbiter
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] grant_idx;
  logic grant_valid;
  modport master(output req, input grant, grant_idx, grant_valid);
  modport slave(input req, output grant, grant_idx, grant_valid);
endinterface

// File: rtl/rr_arbiter4_grant_dec2x4_en.sv
// grant_dec2x4_en: 2-to-4 one-hot decoder with enable
module grant_dec2x4_en
  import rr_arbiter4_pkg::*;
(
  input  logic [IW-1:0]   i_sel,
  input  logic            i_en,
  output logic [NREQ-1:0] o_dec
);
  always_comb o_dec = i_en ? NREQ'(1) << i_sel : '0;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with optional bounded-hold pre-emption
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW = 8
) (
  input logic clk,
  input logic rst,
  rr_arbiter4_if.slave bus
);
  localparam logic [CW-1:0] L_MAX = CW'(MAX_HOLD);
  // With pre-emption disabled the counter only needs to stop wrapping
  localparam logic [CW-1:0] L_SAT = (MAX_HOLD == 0) ? {CW{1'b1}} : L_MAX;
  state_t r_state;
  logic [IW-1:0] r_ptr, r_idx;
  logic [CW-1:0] r_hold;
  logic r_valid;
  logic [NREQ-1:0] w_other;
  logic w_move;
  logic [IW-1:0] w_next;
  always_comb begin
    w_other = bus.req & ~(NREQ'(1) << r_idx);
    w_move = !bus.req[r_idx] || (MAX_HOLD != 0 && r_hold == L_MAX && |w_other);
    w_next = rr_pick(w_other, r_idx + IW'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_idx <= '0;
      r_hold <= '0;
      r_valid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (|bus.req) begin
        r_state <= GRANT;
        r_valid <= 1'b1;
        r_idx <= rr_pick(bus.req, r_ptr);
        r_hold <= CW'(1);
      end
    end else if (w_move) begin
      r_ptr <= r_idx + IW'(1);
      if (|w_other) begin
        r_idx <= w_next;
        r_hold <= CW'(1);
      end else begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_idx <= '0;
        r_hold <= '0;
      end
    end else begin
      r_hold <= (r_hold == L_SAT) ? r_hold : r_hold + CW'(1);
    end
  end
  assign bus.grant_idx = r_idx;
  assign bus.grant_valid = r_valid;
  grant_dec2x4_en u_dec (.i_sel(r_idx), .i_en(r_valid), .o_dec(bus.grant));
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed and random checks of three arbiter configurations against a reference model
module tb_rr_arbiter4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  rr_arbiter4_if b0 ();
  rr_arbiter4_if b1 ();
  rr_arbiter4_if b2 ();
  rr_arbiter4 #(.MAX_HOLD(8), .CW(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
  rr_arbiter4 #(.MAX_HOLD(0), .CW(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
  rr_arbiter4 #(.MAX_HOLD(4), .CW(8)) u2 (.clk(clk), .rst(rst), .bus(b2));
  logic [3:0] rq [3];
  logic [3:0] g [3];
  logic [1:0] gi [3];
  logic gv [3];
  assign b0.req = rq[0];
  assign b1.req = rq[1];
  assign b2.req = rq[2];
  assign g[0] = b0.grant;
  assign g[1] = b1.grant;
  assign g[2] = b2.grant;
  assign gi[0] = b0.grant_idx;
  assign gi[1] = b1.grant_idx;
  assign gi[2] = b2.grant_idx;
  assign gv[0] = b0.grant_valid;
  assign gv[1] = b1.grant_valid;
  assign gv[2] = b2.grant_valid;
  int mh [3] = '{8, 0, 4};
  int m_valid [3];
  int m_idx [3];
  int m_ptr [3];
  int m_hold [3];
  int n_chk = 0;
  int n_fail = 0;
  function automatic int search(logic [3:0] v, int s);
    for (int k = 0; k < 4; k++)
      if (v[(s + k) % 4]) return (s + k) % 4;
    return 0;
  endfunction
  task automatic model(int d, logic [3:0] r);
    logic [3:0] others;
    if (rst) begin
      m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = 0; m_hold[d] = 0;
    end else if (m_valid[d] == 0) begin
      if (r != 0) begin
        m_idx[d] = search(r, m_ptr[d]); m_valid[d] = 1; m_hold[d] = 1;
      end
    end else begin
      others = r;
      others[m_idx[d]] = 1'b0;
      if (!r[m_idx[d]] || (mh[d] != 0 && m_hold[d] == mh[d] && others != 0)) begin
        m_ptr[d] = (m_idx[d] + 1) % 4;
        if (others != 0) begin
          m_idx[d] = search(others, m_ptr[d]); m_hold[d] = 1;
        end else begin
          m_valid[d] = 0; m_idx[d] = 0; m_hold[d] = 0;
        end
      end else if (!(mh[d] != 0 && m_hold[d] >= mh[d])) begin
        m_hold[d] = m_hold[d] + 1;
      end
    end
  endtask
  task automatic chk(string tag, int d, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask
  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk("grant", d, int'(g[d]), m_valid[d] != 0 ? (1 << m_idx[d]) : 0);
      chk("grant_idx", d, int'(gi[d]), m_idx[d]);
      chk("grant_valid", d, int'(gv[d]), m_valid[d]);
    end
    chk("hold_cnt", 0, int'(u0.r_hold), m_hold[0]);
    chk("hold_cnt", 2, int'(u2.r_hold), m_hold[2]);
  endtask
  task automatic step(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic rs);
    rq[0] = a; rq[1] = b; rq[2] = c; rst = rs;
    @(posedge clk);
    for (int d = 0; d < 3; d++) model(d, rq[d]);
    #1 check_all();
  endtask
  initial begin
    int q[$];
    int last;
    int cnt;
    logic [3:0] r;
    rq[0] = '0; rq[1] = '0; rq[2] = '0; rst = 1'b1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int d = 0; d < 3; d++) chk("reset_grant", d, int'(g[d]), 0);
    step(2, 2, 2, 0);
    step(2, 2, 2, 0);
    step(2, 2, 2, 1);
    for (int d = 0; d < 3; d++) chk("rstmid_valid", d, int'(gv[d]), 0);
    step(4'b1010, 4'b1010, 4'b1010, 0);
    for (int d = 0; d < 3; d++) chk("rstmid_idx", d, int'(gi[d]), 1);
    step(0, 0, 0, 1);
    step(4, 4, 4, 0);
    for (int d = 0; d < 3; d++) chk("latency_grant", d, int'(g[d]), 4'b0100);
    for (int i = 0; i < 3; i++) step(4, 4, 4, 0);
    step(0, 0, 0, 0);
    for (int d = 0; d < 3; d++) chk("drop_grant", d, int'(g[d]), 0);
    step(0, 0, 0, 1);
    last = -1;
    for (int i = 0; i < 16; i++) begin
      r = 4'hf;
      if (m_valid[1] != 0 && m_hold[1] == 3) r[m_idx[1]] = 1'b0;
      step(0, r, 0, 0);
      chk("rot_nogap", 1, int'(gv[1]), 1);
      if (gv[1] && int'(gi[1]) != last) begin
        q.push_back(int'(gi[1]));
        last = int'(gi[1]);
      end
    end
    for (int k = 0; k < 5; k++) chk("rot_order", 1, q.size() > k ? q[k] : -1, k % 4);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    cnt = (g[2] == 4'b0001) ? 1 : 0;
    for (int i = 0; i < 20 && g[2] != 4'b1000; i++) begin
      step(0, 0, 4'b1001, 0);
      if (g[2] == 4'b0001) cnt++;
    end
    chk("preempt_cycles", 2, cnt, 4);
    chk("preempt_to3", 2, int'(g[2]), 4'b1000);
    step(0, 0, 4'b1001, 0);
    step(0, 0, 4'b0001, 0);
    chk("preempt_back", 2, int'(g[2]), 4'b0001);
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 4'b0010, 0);
      chk("alone_grant", 2, int'(g[2]), 4'b0010);
    end
    chk("alone_hold", 2, int'(u2.r_hold), 4);
    step(0, 0, 0, 1);
    step(4, 0, 0, 0);
    step(4, 0, 0, 0);
    step(4'b1001, 0, 0, 0);
    chk("sim_arrival", 0, int'(g[0]), 4'b1000);
    for (int i = 0; i < 400; i++)
      step(4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 49) == 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter for a single shared resource.
- Grants exactly one requester at a time. Outputs the winner as a 2-bit index and as a one-hot 4-bit grant, produced by a 2-to-4 decode with enable.
- Holds a grant while the owner keeps its request high. Optionally pre-empts the owner after a bounded hold time if other requesters are waiting.
- Sits between requester blocks and any one-hot-selected shared datapath: mux select, bus enable or memory port.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before forced rotation when others are waiting. 0 disables pre-emption. Legal range 0..255.
- CW, 8: hold-counter width. Must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector. A requester keeps its bit high for the whole time it uses the resource.
- grant  output  4  one-hot grant. All zero when no grant.
- grant_idx  output  2  index of current owner. 0 when grant_valid=0.
- grant_valid  output  1  high while a grant is active.

Behaviour:
- Clocking and reset: all state and outputs are registered.
  - rst sampled high at a clk edge: grant=4'b0000, grant_idx=2'b00, grant_valid=0, state=IDLE, ptr=0, hold_cnt=0.
  - Reset mid-grant drops the grant at that edge, with no completion.
- Priority search: begin at ptr, then ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins. After reset, ptr=0.
- grant is driven by decoding grant_idx, gated by grant_valid. It is never multi-hot.
- State IDLE:
  - req==0: remain in IDLE, outputs stay zero.
  - req!=0 at edge k: winner w is chosen by the search. From edge k, grant_valid=1, grant_idx=w, hold_cnt=1, and the state moves to GRANT.
  - Latency is 1 cycle from req sampled to grant visible.
- State GRANT, owner o. Evaluated each edge in this order:
  1. Release, req[o]==0. Set ptr=o+1.
     - If any other req is set: grant the winner from the search starting at o+1 at the same edge, with hold_cnt=1. This is a zero-gap handoff.
     - Otherwise: go to IDLE with outputs zeroed.
  2. Timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD, and (req with bit o masked)!=0. Set ptr=o+1, then hand off to the winner among the other requests, with hold_cnt=1.
     - The pre-empted owner keeps req high and re-competes normally.
  3. Otherwise keep owner o. hold_cnt increments, saturating at MAX_HOLD.
     - If MAX_HOLD!=0, hold_cnt==MAX_HOLD and no other req is set: the owner keeps the grant and hold_cnt stays at MAX_HOLD, so pre-emption fires as soon as another request appears.
- Simultaneous events:
  - Release together with new requests: handled as release, which hands off immediately.
  - A request arriving on the same edge as a handoff is included in that search.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,... Each requester waits at most 3*MAX_HOLD cycles when MAX_HOLD!=0.
- Requests are not latched. A req pulse that drops before being sampled is lost. Requesters must hold req until granted.

Decomposition:
- Shared package/header holds:
  - state encoding: IDLE=1'b0, GRANT=1'b1;
  - NREQ=4;
  - index width IW=2.
- One natural sub-module: grant_dec2x4_en, a 2-to-4 one-hot decoder with enable. It is instantiated for grant, with enable=grant_valid.
- Round-robin search and hold counter stay inline.

Test Plan:
- Reset mid-grant: req=4'b0010 until granted, then assert rst for 1 cycle → grant=0000, grant_valid=0 at the rst edge. After rst deasserts with req=4'b1010, grant_idx=1 (search from ptr=0).
- Single request latency: req=4'b0100 at edge 1 → grant=0100 and grant_idx=2 from edge 1. Drop req at edge 5 → grant=0000 from edge 5.
- Round-robin rotation: MAX_HOLD=0, req=4'b1111. Each owner drops its bit for one cycle after 3 cycles of grant → grant sequence 0001,0010,0100,1000,0001 with no gap cycles.
- Pre-emption: MAX_HOLD=4, req[0] held high, req[3] raised at cycle 2 → owner 0 for exactly 4 grant cycles, then grant=1000. After req[3] drops, grant returns to 0001.
- No pre-emption when alone: MAX_HOLD=4, only req[1] high for 20 cycles → grant=0010 throughout, hold_cnt saturates at 4.
- Handoff with simultaneous arrival: owner 2 releases on the same edge that req[0] and req[3] rise → grant=1000 at that edge (search from 3).
